cordic_sched: RTL and testbench
===============================

# cordic_sched

Scheduler that shares one `cordic_comp` datapath between `NUM_REQ` requesters. It arbitrates among pending operand requests and loads the winner into the CORDIC by holding the CORDIC reset for one cycle. It then releases reset for the fixed iteration count, captures x/y/z and returns them on a response channel tagged with the requester index. It sits between the operand producers and the single `cordic_comp` instance, and drives every `cordic_comp` input port.

## Interface
- `NUM_REQ`, 4: number of requesters (≥2).
- `WHOLE_BIT_WIDTH`, 3: integer bits per operand.
- `DECIMAL_BIT_WIDTH`, 13: fraction bits per operand.
- `ITERATIONS`, `WHOLE_BIT_WIDTH+DECIMAL_BIT_WIDTH` (16): cycles the CORDIC runs per operation.
- `clk`  in  1  single clock.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  NUM_REQ  per-requester request.
- `req_ready`  out  NUM_REQ  one-hot accept; `(state==IDLE) & grant[i]`, combinational from `req_valid`.
- `req_x_whole`, `req_y_whole`, `req_z_whole`  in  NUM_REQ*WHOLE_BIT_WIDTH  packed integer parts; requester i is slice i.
- `req_x_decimal`, `req_y_decimal`, `req_z_decimal`  in  NUM_REQ*DECIMAL_BIT_WIDTH  packed fraction parts.
- `req_mode`  in  NUM_REQ  0 = rotation, 1 = vectoring.
- `req_coord`  in  2*NUM_REQ  coordinate system: 0 = linear, 1 = circular; other codes are passed through unchanged.
- `rsp_valid`  out  1  result available.
- `rsp_ready`  in  1  consumer accepts.
- `rsp_id`  out  $clog2(NUM_REQ)  requester index of the result.
- `rsp_x`, `rsp_y`, `rsp_z`  out  WHOLE+DECIMAL  captured results.
- `cor_x_whole`, `cor_y_whole`, `cor_z_whole`  out  WHOLE_BIT_WIDTH  drive to CORDIC.
- `cor_x_decimal`, `cor_y_decimal`, `cor_z_decimal`  out  DECIMAL_BIT_WIDTH  drive to CORDIC.
- `cor_mode`  out  1;  `cor_coord`  out  2;  `cor_rst`  out  1  drive to CORDIC.
- `cor_x`, `cor_y`, `cor_z`  in  WHOLE+DECIMAL  CORDIC outputs.

## Operation
- FSM states: IDLE → LOAD → RUN → RESP → IDLE.
- IDLE: if any `req_valid` is high, the arbiter grants one requester. On the handshake:
  - the granted operands, mode and coord are registered into the `cor_*` registers;
  - the round-robin pointer is set to the granted index;
  - the FSM goes to LOAD.
- LOAD: one cycle with `cor_rst=1` and the operands stable, so the CORDIC loads them.
- RUN: `cor_rst=0`. An iteration counter counts 0..ITERATIONS-1.
  - On the edge ending count ITERATIONS-1, `cor_x/y/z` are captured into `rsp_x/y/z` and the granted index into `rsp_id`.
  - On the same edge `rsp_valid` is set and the FSM goes to RESP.
- RESP: `cor_rst=1`. `rsp_*` are held stable until `rsp_valid & rsp_ready`; the FSM then returns to IDLE and clears `rsp_valid`.
- `cor_rst` is 1 in every state except RUN.
- `cor_*` operands change only on a request handshake.
- Round-robin: the search starts at pointer+1 modulo NUM_REQ. The pointer resets to NUM_REQ-1, so requester 0 wins first.
- No request is accepted outside IDLE. `req_valid` is held by requesters until `req_ready`.
- `rst` in any state, including mid-RUN, has this effect on the next edge:
  - FSM goes to IDLE, counter to 0, pointer to NUM_REQ-1;
  - any in-flight result is discarded with no response.
- Reset values: `req_ready` 0; `rsp_valid` 0; `rsp_id` 0; `rsp_x/y/z` 0; all `cor_*` operands 0; `cor_mode` 0; `cor_coord` 0; `cor_rst` 1.

## Timing
- Handshake at cycle 0 → LOAD at cycle 1 → RUN at cycles 2..ITERATIONS+1 → `rsp_valid` high from cycle ITERATIONS+2 (18 at defaults).
- Minimum issue interval is ITERATIONS+3 cycles. This is achieved when `rsp_ready` is high in the first RESP cycle, giving a return to IDLE at cycle ITERATIONS+3.
- `req_ready` is combinational in IDLE. All other outputs are registered.

## Configuration
- `CORDIC_SCHED_PRIO_EN` defined: requester 0 has fixed highest priority whenever `req_valid[0]` is high. The remaining requesters are round-robin among themselves.
- Not defined: pure round-robin over all requesters.

## Structure
- `cordic_sched_pkg`:
  - FSM state enum;
  - `FIXED_W` width function (`WHOLE+DECIMAL`);
  - `ID_W` function (`$clog2`).
- One sub-module, `cordic_rr_arb`, contains:
  - inputs: request vector, pointer, enable;
  - output: one-hot grant plus encoded index;
  - the `CORDIC_SCHED_PRIO_EN` override.

## Test plan
- **Single request.** Only `req_valid[0]`, with x=1.5 (whole 1, decimal 13'h1000), y=0, z=2.0, mode 0, coord 0 → all of the following:
  - `req_ready[0]` in the same cycle;
  - `cor_rst` high 1 cycle, then low 16 cycles;
  - `rsp_valid` at cycle 18 with `rsp_id`=0 and `rsp_x/y/z` equal to `cor_x/y/z` at the last RUN edge.
- **Fairness.** All four requesters held valid → grant order 0, 1, 2, 3, 0; each `rsp_id` matches its grant; issue interval 19 cycles with `rsp_ready`=1.
- **Backpressure.** `rsp_ready` low for 10 cycles → `rsp_valid`/`rsp_id`/`rsp_x/y/z` stable, `req_ready` stays 0, `cor_rst`=1; next grant in the cycle after acceptance.
- **Reset mid-operation.** `rst` at RUN cycle 8 → next cycle `rsp_valid`=0 and `cor_rst`=1, no response ever for that request; the next grant goes to requester 0.
- **Vectoring on requester 3.** x=1, y=4, z=0, mode 1, coord 1 → `cor_mode`=1 and `cor_coord`=01 stable through LOAD and RUN; `rsp_id`=3.
- **Priority macro.** `req_valid[0]` and `req_valid[2]` held high → with `CORDIC_SCHED_PRIO_EN`, grants 0, 0, 0; without it, grants 0, 2, 0, 2.

Source files
------------

// File: rtl/cordic_sched_pkg.sv
// Shared types and width helpers for the CORDIC scheduler slice.
package cordic_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_RESP
  } state_t;

  function automatic int FIXED_W(input int whole_w, input int decimal_w);
    return whole_w + decimal_w;
  endfunction

  function automatic int ID_W(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage

// File: rtl/cordic_sched_if.sv
// Request/response channel bundle between operand producers and the scheduler.
interface cordic_sched_if #(
  parameter int NUM_REQ           = 4,
  parameter int WHOLE_BIT_WIDTH   = 3,
  parameter int DECIMAL_BIT_WIDTH = 13
);
  import cordic_sched_pkg::*;

  localparam int FW = FIXED_W(WHOLE_BIT_WIDTH, DECIMAL_BIT_WIDTH);
  localparam int IW = ID_W(NUM_REQ);

  logic [NUM_REQ-1:0]                   req_valid;
  logic [NUM_REQ-1:0]                   req_ready;
  logic [NUM_REQ*WHOLE_BIT_WIDTH-1:0]   req_x_whole;
  logic [NUM_REQ*WHOLE_BIT_WIDTH-1:0]   req_y_whole;
  logic [NUM_REQ*WHOLE_BIT_WIDTH-1:0]   req_z_whole;
  logic [NUM_REQ*DECIMAL_BIT_WIDTH-1:0] req_x_decimal;
  logic [NUM_REQ*DECIMAL_BIT_WIDTH-1:0] req_y_decimal;
  logic [NUM_REQ*DECIMAL_BIT_WIDTH-1:0] req_z_decimal;
  logic [NUM_REQ-1:0]                   req_mode;
  logic [2*NUM_REQ-1:0]                 req_coord;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [IW-1:0] rsp_id;
  logic [FW-1:0] rsp_x;
  logic [FW-1:0] rsp_y;
  logic [FW-1:0] rsp_z;

  modport master (
    output req_valid, req_x_whole, req_y_whole, req_z_whole,
           req_x_decimal, req_y_decimal, req_z_decimal, req_mode, req_coord,
           rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_x, rsp_y, rsp_z
  );

  modport slave (
    input  req_valid, req_x_whole, req_y_whole, req_z_whole,
           req_x_decimal, req_y_decimal, req_z_decimal, req_mode, req_coord,
           rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_x, rsp_y, rsp_z
  );

endinterface

// File: rtl/cordic_rr_arb.sv
// Round-robin arbiter: search starts one past i_ptr. With CORDIC_SCHED_PRIO_EN
// defined, requester 0 overrides the rotation whenever it is requesting.
module cordic_rr_arb
  import cordic_sched_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IW      = ID_W(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IW-1:0]      i_ptr,
  input  logic               i_en,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [IW-1:0]      o_idx
);

  int   w_dist;
  int   w_best;
  int   w_best_dist;
  logic w_found;

  always_comb begin
    // NOTE: every variable gets a default before any conditional update, so
    // no path leaves a value held over and no latch is inferred.
    w_dist      = 0;
    w_best      = 0;
    w_best_dist = NUM_REQ;
    o_grant     = '0;
    // Distance from the slot after the pointer; smallest requesting distance wins.
    for (int i = 0; i < NUM_REQ; i++) begin
      w_dist = i - int'(i_ptr) - 1;
      if (w_dist < 0) w_dist = w_dist + NUM_REQ;
      if (i_req[i] && (w_dist < w_best_dist)) begin
        w_best_dist = w_dist;
        w_best      = i;
      end
    end
`ifdef CORDIC_SCHED_PRIO_EN
    if (i_req[0]) begin
      w_best_dist = 0;
      w_best      = 0;
    end
`endif
    w_found = (w_best_dist < NUM_REQ);
    o_idx   = IW'(w_best);
    for (int i = 0; i < NUM_REQ; i++) begin
      o_grant[i] = i_en && w_found && (w_best == i);
    end
  end

endmodule

// File: rtl/cordic_sched.sv
// Time-shares one cordic_comp between NUM_REQ requesters: arbitrate, load under
// cordic reset, run ITERATIONS cycles, return the tagged result. Optional
// CORDIC_SCHED_PRIO_EN gives requester 0 fixed priority.
module cordic_sched
  import cordic_sched_pkg::*;
#(
  parameter int NUM_REQ           = 4,
  parameter int WHOLE_BIT_WIDTH   = 3,
  parameter int DECIMAL_BIT_WIDTH = 13,
  parameter int ITERATIONS        = WHOLE_BIT_WIDTH + DECIMAL_BIT_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  cordic_sched_if.slave                bus,
  output logic [WHOLE_BIT_WIDTH-1:0]   cor_x_whole,
  output logic [WHOLE_BIT_WIDTH-1:0]   cor_y_whole,
  output logic [WHOLE_BIT_WIDTH-1:0]   cor_z_whole,
  output logic [DECIMAL_BIT_WIDTH-1:0] cor_x_decimal,
  output logic [DECIMAL_BIT_WIDTH-1:0] cor_y_decimal,
  output logic [DECIMAL_BIT_WIDTH-1:0] cor_z_decimal,
  output logic                         cor_mode,
  output logic [1:0]                   cor_coord,
  output logic                         cor_rst,
  input  logic [FIXED_W(WHOLE_BIT_WIDTH, DECIMAL_BIT_WIDTH)-1:0] cor_x,
  input  logic [FIXED_W(WHOLE_BIT_WIDTH, DECIMAL_BIT_WIDTH)-1:0] cor_y,
  input  logic [FIXED_W(WHOLE_BIT_WIDTH, DECIMAL_BIT_WIDTH)-1:0] cor_z
);

  localparam int FW    = FIXED_W(WHOLE_BIT_WIDTH, DECIMAL_BIT_WIDTH);
  localparam int IW    = ID_W(NUM_REQ);
  localparam int CNT_W = $clog2(ITERATIONS + 1);
  localparam int WB    = WHOLE_BIT_WIDTH;
  localparam int DB    = DECIMAL_BIT_WIDTH;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [IW-1:0]    r_ptr;
  logic             r_rsp_valid;
  logic [IW-1:0]    r_rsp_id;
  logic [FW-1:0]    r_rsp_x;
  logic [FW-1:0]    r_rsp_y;
  logic [FW-1:0]    r_rsp_z;

  logic             w_arb_en;
  logic [NUM_REQ-1:0] w_grant;
  logic [IW-1:0]    w_idx;
  logic [WB-1:0]    w_sel_xw, w_sel_yw, w_sel_zw;
  logic [DB-1:0]    w_sel_xd, w_sel_yd, w_sel_zd;
  logic             w_sel_mode;
  logic [1:0]       w_sel_coord;

  // Gating with rst keeps a requester from seeing an accept that reset discards.
  assign w_arb_en = (r_state == ST_IDLE) && !rst;

  cordic_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_arb (
    .i_req   (bus.req_valid),
    .i_ptr   (r_ptr),
    .i_en    (w_arb_en),
    .o_grant (w_grant),
    .o_idx   (w_idx)
  );

  assign bus.req_ready = w_grant;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_x     = r_rsp_x;
  assign bus.rsp_y     = r_rsp_y;
  assign bus.rsp_z     = r_rsp_z;

  always_comb begin
    w_sel_xw    = '0;
    w_sel_yw    = '0;
    w_sel_zw    = '0;
    w_sel_xd    = '0;
    w_sel_yd    = '0;
    w_sel_zd    = '0;
    w_sel_mode  = 1'b0;
    w_sel_coord = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_idx == IW'(i)) begin
        w_sel_xw    = bus.req_x_whole[i*WB +: WB];
        w_sel_yw    = bus.req_y_whole[i*WB +: WB];
        w_sel_zw    = bus.req_z_whole[i*WB +: WB];
        w_sel_xd    = bus.req_x_decimal[i*DB +: DB];
        w_sel_yd    = bus.req_y_decimal[i*DB +: DB];
        w_sel_zd    = bus.req_z_decimal[i*DB +: DB];
        w_sel_mode  = bus.req_mode[i];
        w_sel_coord = bus.req_coord[2*i +: 2];
      end
    end
  end

  // NOTE: all state here uses non-blocking <= so every register samples the
  // pre-edge value of every other register, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_ptr         <= IW'(NUM_REQ - 1);
      r_rsp_valid   <= 1'b0;
      r_rsp_id      <= '0;
      r_rsp_x       <= '0;
      r_rsp_y       <= '0;
      r_rsp_z       <= '0;
      cor_x_whole   <= '0;
      cor_y_whole   <= '0;
      cor_z_whole   <= '0;
      cor_x_decimal <= '0;
      cor_y_decimal <= '0;
      cor_z_decimal <= '0;
      cor_mode      <= 1'b0;
      cor_coord     <= '0;
      cor_rst       <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_grant) begin
            cor_x_whole   <= w_sel_xw;
            cor_y_whole   <= w_sel_yw;
            cor_z_whole   <= w_sel_zw;
            cor_x_decimal <= w_sel_xd;
            cor_y_decimal <= w_sel_yd;
            cor_z_decimal <= w_sel_zd;
            cor_mode      <= w_sel_mode;
            cor_coord     <= w_sel_coord;
            r_ptr         <= w_idx;
            r_state       <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          cor_rst <= 1'b0;
          r_cnt   <= '0;
          r_state <= ST_RUN;
        end
        ST_RUN: begin
          if (r_cnt == CNT_W'(ITERATIONS - 1)) begin
            // r_ptr still holds the granted index for the whole operation.
            r_rsp_x     <= cor_x;
            r_rsp_y     <= cor_y;
            r_rsp_z     <= cor_z;
            r_rsp_id    <= r_ptr;
            r_rsp_valid <= 1'b1;
            cor_rst     <= 1'b1;
            r_cnt       <= '0;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_sched.sv
// Scoreboard bench for cordic_sched: transaction-level reference model with
// timestamped expectations, directed plan items plus a randomized phase.
module tb_cordic_sched;
  import cordic_sched_pkg::*;

  localparam int N    = 4;
  localparam int WB   = 3;
  localparam int DB   = 13;
  localparam int ITER = WB + DB;
  localparam int FW   = WB + DB;

  typedef struct packed {
    logic [WB-1:0] xw;
    logic [DB-1:0] xd;
    logic [WB-1:0] yw;
    logic [DB-1:0] yd;
    logic [WB-1:0] zw;
    logic [DB-1:0] zd;
    logic          mode;
    logic [1:0]    coord;
  } op_t;

  typedef struct {
    int            id;
    logic [FW-1:0] x;
    logic [FW-1:0] y;
    logic [FW-1:0] z;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cordic_sched_if #(.NUM_REQ(N), .WHOLE_BIT_WIDTH(WB), .DECIMAL_BIT_WIDTH(DB)) bus ();

  logic [WB-1:0] cor_x_whole, cor_y_whole, cor_z_whole;
  logic [DB-1:0] cor_x_decimal, cor_y_decimal, cor_z_decimal;
  logic          cor_mode;
  logic [1:0]    cor_coord;
  logic          cor_rst;
  logic [FW-1:0] cor_x, cor_y, cor_z;

  cordic_sched #(
    .NUM_REQ(N), .WHOLE_BIT_WIDTH(WB), .DECIMAL_BIT_WIDTH(DB), .ITERATIONS(ITER)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .cor_x_whole   (cor_x_whole),
    .cor_y_whole   (cor_y_whole),
    .cor_z_whole   (cor_z_whole),
    .cor_x_decimal (cor_x_decimal),
    .cor_y_decimal (cor_y_decimal),
    .cor_z_decimal (cor_z_decimal),
    .cor_mode      (cor_mode),
    .cor_coord     (cor_coord),
    .cor_rst       (cor_rst),
    .cor_x         (cor_x),
    .cor_y         (cor_y),
    .cor_z         (cor_z)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  // Stimulus state.
  op_t          ops [N];
  logic [N-1:0] valid     = '0;
  logic [N-1:0] hold_mask = '0;
  int           rand_pct  = 0;
  int           rdy_mode  = 1;
  logic [N-1:0] acc       = '0;

  // Reference model state.
  bit   m_busy = 1'b0;
  int   m_hs   = 0;
  int   m_ptr  = N - 1;
  op_t  m_ops  = '0;
  rsp_t sb [$];

  // Observed DUT handshakes.
  int dut_gnt_log [$];
  int dut_hs_log  [$];
  int rsp_acc_cyc = -1;

  // The stand-in CORDIC output is a known function of the cycle number, so the
  // value present during the last RUN cycle is predictable from the grant time.
  function automatic logic [FW-1:0] fx(input int k);
    return FW'(k * 37 + 5);
  endfunction
  function automatic logic [FW-1:0] fy(input int k);
    return FW'(k * 101) ^ 16'h5a5a;
  endfunction
  function automatic logic [FW-1:0] fz(input int k);
    return FW'(k * 7 + 1000);
  endfunction

  function automatic int model_pick(input logic [N-1:0] v, input int ptr);
`ifdef CORDIC_SCHED_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int off = 1; off <= N; off++) begin
      if (v[(ptr + off) % N]) return (ptr + off) % N;
    end
    return -1;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic op_t rand_op();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[$bits(op_t)-1:0];
  endfunction

  task automatic apply();
    bus.req_valid = valid;
    for (int i = 0; i < N; i++) begin
      bus.req_x_whole[i*WB +: WB]   = ops[i].xw;
      bus.req_y_whole[i*WB +: WB]   = ops[i].yw;
      bus.req_z_whole[i*WB +: WB]   = ops[i].zw;
      bus.req_x_decimal[i*DB +: DB] = ops[i].xd;
      bus.req_y_decimal[i*DB +: DB] = ops[i].yd;
      bus.req_z_decimal[i*DB +: DB] = ops[i].zd;
      bus.req_mode[i]               = ops[i].mode;
      bus.req_coord[2*i +: 2]       = ops[i].coord;
    end
  endtask

  // One clock: advance the cycle count, drive the CORDIC stand-in, retire
  // accepted requests and raise new ones.
  task automatic tick();
    @(posedge clk);
    #2;
    cyc++;
    cor_x = fx(cyc);
    cor_y = fy(cyc);
    cor_z = fz(cyc);
    for (int i = 0; i < N; i++) begin
      if (acc[i]) valid[i] = 1'b0;
      if (!valid[i] && (hold_mask[i] || ($urandom_range(99) < rand_pct))) begin
        valid[i] = 1'b1;
        ops[i]   = rand_op();
      end
    end
    case (rdy_mode)
      0:       bus.rsp_ready = 1'b0;
      1:       bus.rsp_ready = 1'b1;
      default: bus.rsp_ready = 1'($urandom_range(1));
    endcase
    apply();
  endtask

  task automatic post(input int i, input op_t op);
    valid[i] = 1'b1;
    ops[i]   = op;
    apply();
  endtask

  task automatic do_reset();
    hold_mask = '0;
    rand_pct  = 0;
    valid     = '0;
    rst       = 1'b1;
    apply();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_grants(input int n, input int budget);
    int t = 0;
    while (dut_gnt_log.size() < n && t < budget) begin
      tick();
      t++;
    end
    if (dut_gnt_log.size() < n) begin
      checks++;
      errors++;
      $display("FAIL wait_grants got=%0d expected=%0d", dut_gnt_log.size(), n);
    end
  endtask

  task automatic drain(input int budget);
    int t = 0;
    hold_mask = '0;
    rand_pct  = 0;
    rdy_mode  = 1;
    while ((m_busy || valid != '0) && t < budget) begin
      tick();
      t++;
    end
    if (m_busy || valid != '0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout busy=%0d valid=%0h", m_busy, valid);
    end
  endtask

  // Monitor: compares every cycle against the model, then advances the model.
  task automatic check_cycle();
    int           k;
    int           pick;
    logic [N-1:0] exp_rdy;
    logic         exp_crst;
    logic         exp_rv;
    rsp_t         e;
    k        = cyc;
    pick     = model_pick(valid, m_ptr);
    exp_rdy  = '0;
    if (!m_busy && !rst && pick >= 0) exp_rdy = N'(1) << pick;
    exp_crst = !(m_busy && k >= m_hs + 2 && k <= m_hs + ITER + 1);
    exp_rv   = m_busy && (k >= m_hs + ITER + 2);

    check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    check("cor_rst", 64'(cor_rst), 64'(exp_crst));
    check("rsp_valid", 64'(bus.rsp_valid), 64'(exp_rv));
    check("cor_ops", 64'({cor_x_whole, cor_x_decimal, cor_y_whole, cor_y_decimal,
                          cor_z_whole, cor_z_decimal, cor_mode, cor_coord}), 64'(m_ops));
    if (exp_rv && bus.rsp_valid === 1'b1 && sb.size() > 0) begin
      e = sb[0];
      check("rsp_id", 64'(bus.rsp_id), 64'(e.id));
      check("rsp_x", 64'(bus.rsp_x), 64'(e.x));
      check("rsp_y", 64'(bus.rsp_y), 64'(e.y));
      check("rsp_z", 64'(bus.rsp_z), 64'(e.z));
    end

    acc = bus.req_valid & bus.req_ready;
    if (acc != '0) begin
      dut_hs_log.push_back(k);
      dut_gnt_log.push_back(($countones(acc) == 1) ? $clog2(acc) : -1);
    end
    if (bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) rsp_acc_cyc = k;

    if (rst) begin
      m_busy = 1'b0;
      m_ptr  = N - 1;
      m_ops  = '0;
      sb.delete();
    end else if (m_busy) begin
      if (exp_rv && bus.rsp_ready) begin
        m_busy = 1'b0;
        void'(sb.pop_front());
      end
    end else if (pick >= 0) begin
      m_busy = 1'b1;
      m_hs   = k;
      m_ptr  = pick;
      m_ops  = ops[pick];
      e.id = pick;
      e.x  = fx(k + ITER + 1);
      e.y  = fy(k + ITER + 1);
      e.z  = fz(k + ITER + 1);
      sb.push_back(e);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) check_cycle();
    end
  end

  initial begin
    op_t o;
    int  exp_seq [5];
    int  post_cyc;
    int  hs0;
    for (int i = 0; i < N; i++) ops[i] = '0;
    cor_x = fx(0);
    cor_y = fy(0);
    cor_z = fz(0);
    bus.rsp_ready = 1'b1;
    apply();
    tick();
    chk_en = 1'b1;
    do_reset();

    // Reset state.
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("rst_rsp_id", 64'(bus.rsp_id), 64'(0));
    check("rst_rsp_xyz", 64'({bus.rsp_x, bus.rsp_y, bus.rsp_z}), 64'(0));
    check("rst_cor_rst", 64'(cor_rst), 64'(1));

    // Single request: x=1.5, y=0, z=2.0, rotation, linear.
    dut_gnt_log.delete(); dut_hs_log.delete();
    o = '0; o.xw = 3'd1; o.xd = 13'h1000; o.zw = 3'd2;
    post(0, o);
    post_cyc = cyc;
    wait_grants(1, 10);
    if (dut_gnt_log.size() >= 1) begin
      check("single_id", 64'(dut_gnt_log[0]), 64'(0));
      check("single_same_cycle", 64'(dut_hs_log[0]), 64'(post_cyc));
    end
    drain(60);

    // Fairness with all requesters held valid.
    do_reset();
    dut_gnt_log.delete(); dut_hs_log.delete();
`ifdef CORDIC_SCHED_PRIO_EN
    exp_seq = '{0, 0, 0, 0, 0};
`else
    exp_seq = '{0, 1, 2, 3, 0};
`endif
    hold_mask = '1;
    wait_grants(5, 200);
    if (dut_gnt_log.size() >= 5) begin
      for (int i = 0; i < 5; i++) check($sformatf("fair_grant%0d", i), 64'(dut_gnt_log[i]), 64'(exp_seq[i]));
      for (int i = 1; i < 5; i++) check($sformatf("fair_gap%0d", i), 64'(dut_hs_log[i] - dut_hs_log[i-1]), 64'(ITER + 3));
    end
    drain(200);

    // Backpressure: hold rsp_ready low for 10 RESP cycles with another request waiting.
    dut_gnt_log.delete(); dut_hs_log.delete();
    rdy_mode = 0;
    bus.rsp_ready = 1'b0;
    post(1, rand_op());
    wait_grants(1, 10);
    hs0 = (dut_hs_log.size() > 0) ? dut_hs_log[0] : cyc;
    post(2, rand_op());
    while (cyc < hs0 + ITER + 12) tick();
    rdy_mode = 1;
    bus.rsp_ready = 1'b1;
    wait_grants(2, 10);
    if (dut_hs_log.size() >= 2) check("bp_next_grant", 64'(dut_hs_log[1]), 64'(rsp_acc_cyc + 1));
    drain(60);

    // Reset in the middle of RUN: response dropped, pointer back to N-1.
    dut_gnt_log.delete(); dut_hs_log.delete();
    post(1, rand_op());
    wait_grants(1, 10);
    hs0 = (dut_hs_log.size() > 0) ? dut_hs_log[0] : cyc;
    post(0, rand_op());
    post(2, rand_op());
    while (cyc < hs0 + 10) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_grants(2, 10);
    if (dut_gnt_log.size() >= 2) check("rst_next_grant", 64'(dut_gnt_log[1]), 64'(0));
    drain(100);

    // Vectoring on requester 3: x=1, y=4, z=0, circular.
    dut_gnt_log.delete(); dut_hs_log.delete();
    o = '0; o.xw = 3'd1; o.yw = 3'd4; o.mode = 1'b1; o.coord = 2'b01;
    post(3, o);
    wait_grants(1, 10);
    if (dut_gnt_log.size() >= 1) check("vec_id", 64'(dut_gnt_log[0]), 64'(3));
    drain(60);

    // Requesters 0 and 2 held valid.
    do_reset();
    dut_gnt_log.delete(); dut_hs_log.delete();
`ifdef CORDIC_SCHED_PRIO_EN
    exp_seq = '{0, 0, 0, 0, 0};
`else
    exp_seq = '{0, 2, 0, 2, 0};
`endif
    hold_mask = 4'b0101;
    wait_grants(4, 150);
    if (dut_gnt_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) check($sformatf("prio_grant%0d", i), 64'(dut_gnt_log[i]), 64'(exp_seq[i]));
    end
    drain(200);

    // Randomized traffic with random backpressure and one reset pulse.
    rand_pct = 25;
    rdy_mode = 2;
    for (int t = 0; t < 800; t++) begin
      tick();
      if (t == 400) rst = 1'b1;
      if (t == 401) rst = 1'b0;
    end
    drain(400);
    check("sb_empty", 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
